data_memory: RTL and testbench

Responder side of the CPU data-memory interface. It accepts the pipeline's encoded read/write requests, stalls the core through BUSYWAIT for a fixed, parameterised access latency, and then performs byte, half-word or word accesses on a word-organised storage array. Loads are returned sign- or zero-extended. It sits between the MEM stage's data-memory ports and on-chip storage, and stands in for a future data cache.

---
 rtl/mem_if_pkg.sv | 34 +++
 rtl/mem_lane_align.sv | 47 ++++
 rtl/data_memory.sv | 146 ++++++++++++++
 tb/tb_data_memory.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
// Shared data-memory interface encodings, FSM states and the latched request payload.
// The CPU control unit imports the same op encodings.
package mem_if_pkg;

    localparam int unsigned WORD_W = 32;

    // {enable, funct3} load encodings
    localparam logic [3:0] MEM_LB  = 4'b1000;
    localparam logic [3:0] MEM_LH  = 4'b1001;
    localparam logic [3:0] MEM_LW  = 4'b1010;
    localparam logic [3:0] MEM_LBU = 4'b1100;
    localparam logic [3:0] MEM_LHU = 4'b1101;

    // {enable, funct3[1:0]} store encodings
    localparam logic [2:0] MEM_SB  = 3'b100;
    localparam logic [2:0] MEM_SH  = 3'b101;
    localparam logic [2:0] MEM_SW  = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } mem_state_t;

    typedef struct packed {
        logic              wr;
        logic              rd;
        logic              conflict;
        logic [2:0]        funct3;
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane extraction/extension for loads, lane merge for stores, and the
// misalignment flag. Purely combinational.
module mem_lane_align
    import mem_if_pkg::*;
(
    input  logic [WORD_W-1:0] i_word,
    input  logic [1:0]        i_addr_lo,
    input  logic [2:0]        i_funct3,
    input  logic [WORD_W-1:0] i_wdata,
    output logic [WORD_W-1:0] o_load_data_c,
    output logic [WORD_W-1:0] o_store_word_c,
    output logic              o_misaligned_c
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte         = i_word[{i_addr_lo, 3'b000} +: 8];
        w_half         = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
        o_load_data_c  = i_word;
        o_store_word_c = i_word;
        o_misaligned_c = 1'b0;
        // funct3[2] selects zero extension; half/word lanes ignore the low address bits
        case (i_funct3[1:0])
            2'b00: begin
                o_load_data_c = i_funct3[2] ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
                o_store_word_c[{i_addr_lo, 3'b000} +: 8] = i_wdata[7:0];
            end
            2'b01: begin
                o_load_data_c = i_funct3[2] ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
                if (i_addr_lo[1]) begin
                    o_store_word_c[31:16] = i_wdata[15:0];
                end else begin
                    o_store_word_c[15:0] = i_wdata[15:0];
                end
                o_misaligned_c = i_addr_lo[0];
            end
            default: begin
                o_load_data_c  = i_word;
                o_store_word_c = i_wdata;
                o_misaligned_c = |i_addr_lo;
            end
        endcase
    end

endmodule

// File: rtl/data_memory.sv
// Fixed-latency data-memory responder: stalls the core via BUSYWAIT, then performs
// byte/half/word loads and stores on a word-organised array.
module data_memory
    import mem_if_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS    = 1024,
    parameter int unsigned ACCESS_LATENCY = 3
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [3:0]        DATA_MEM_READ,
    input  logic [2:0]        DATA_MEM_WRITE,
    input  logic [WORD_W-1:0] DATA_MEM_ADDR,
    input  logic [WORD_W-1:0] DATA_MEM_WRITE_DATA,
    output logic [WORD_W-1:0] DATA_MEM_READ_DATA,
    output logic              DATA_MEM_BUSYWAIT,
    output logic              DATA_MEM_ERROR
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = (ACCESS_LATENCY > 1) ? $clog2(ACCESS_LATENCY) : 1;

    mem_state_t        r_state;
    mem_state_t        w_state_nxt;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     w_cnt_nxt;
    mem_req_t          r_req;
    mem_req_t          w_in_req;
    mem_req_t          w_cur;
    logic [WORD_W-1:0] r_rdata;
    logic              r_error;
    logic [WORD_W-1:0] r_mem [DEPTH_WORDS];

    logic              w_pending;
    logic              w_busy;
    logic              w_latch;
    logic              w_do_access;
    logic              w_in_range;
    logic [AW-1:0]     w_mem_idx;
    logic [WORD_W-1:0] w_old_word;
    logic [WORD_W-1:0] w_load_data;
    logic [WORD_W-1:0] w_store_word;
    logic              w_misaligned;
    logic              w_err;

    assign w_pending = DATA_MEM_READ[3] | DATA_MEM_WRITE[2];

    // Write wins over a simultaneous read; the read is dropped and flagged
    always_comb begin
        w_in_req          = '0;
        w_in_req.wr       = DATA_MEM_WRITE[2];
        w_in_req.rd       = DATA_MEM_READ[3] & ~DATA_MEM_WRITE[2];
        w_in_req.conflict = DATA_MEM_READ[3] & DATA_MEM_WRITE[2];
        w_in_req.funct3   = DATA_MEM_WRITE[2] ? {1'b0, DATA_MEM_WRITE[1:0]} : DATA_MEM_READ[2:0];
        w_in_req.addr     = DATA_MEM_ADDR;
        w_in_req.wdata    = DATA_MEM_WRITE_DATA;
    end

    // A single-cycle latency completes straight from IDLE using the live ports
    assign w_cur        = (r_state == ST_IDLE) ? w_in_req : r_req;
    assign w_in_range   = ({2'b00, w_cur.addr[31:2]} < 32'(DEPTH_WORDS));
    assign w_mem_idx    = w_cur.addr[AW+1:2];
    assign w_old_word   = w_in_range ? r_mem[w_mem_idx] : '0;
    assign w_err        = w_misaligned | ~w_in_range | w_cur.conflict;

    mem_lane_align u_lane_align (
        .i_word         (w_old_word),
        .i_addr_lo      (w_cur.addr[1:0]),
        .i_funct3       (w_cur.funct3),
        .i_wdata        (w_cur.wdata),
        .o_load_data_c  (w_load_data),
        .o_store_word_c (w_store_word),
        .o_misaligned_c (w_misaligned)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_busy      = 1'b0;
        w_latch     = 1'b0;
        w_do_access = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pending) begin
                    w_busy    = 1'b1;
                    w_latch   = 1'b1;
                    w_cnt_nxt = CW'(ACCESS_LATENCY - 1);
                    if (ACCESS_LATENCY == 1) begin
                        w_do_access = 1'b1;
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                w_busy = 1'b1;
                if (r_cnt == CW'(1)) begin
                    w_do_access = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_req   <= '0;
            r_rdata <= '0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_error <= w_do_access & w_err;
            if (w_latch) begin
                r_req <= w_in_req;
            end
            if (w_do_access && w_cur.rd) begin
                r_rdata <= w_in_range ? w_load_data : '0;
            end
        end
    end

    // Storage is never cleared; a reset landing on the completion edge suppresses the write
    always_ff @(posedge CLK) begin
        if (RESET && w_do_access && w_cur.wr && w_in_range) begin
            r_mem[w_mem_idx] <= w_store_word;
        end
    end

    assign DATA_MEM_BUSYWAIT  = RESET & w_busy;
    assign DATA_MEM_READ_DATA = r_rdata;
    assign DATA_MEM_ERROR     = r_error;

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory against a byte-addressed reference model.
module tb_data_memory;
    import mem_if_pkg::*;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned LAT   = 3;

    logic        clk;
    logic        rst_n;
    logic [3:0]  mem_read;
    logic [2:0]  mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] read_data;
    logic        busywait;
    logic        error;

    int checks;
    int failures;

    logic [7:0]  mb [DEPTH*4];
    logic [31:0] exp_rd;

    data_memory #(.DEPTH_WORDS(DEPTH), .ACCESS_LATENCY(LAT)) dut (
        .CLK                 (clk),
        .RESET               (rst_n),
        .DATA_MEM_READ       (mem_read),
        .DATA_MEM_WRITE      (mem_write),
        .DATA_MEM_ADDR       (mem_addr),
        .DATA_MEM_WRITE_DATA (mem_wdata),
        .DATA_MEM_READ_DATA  (read_data),
        .DATA_MEM_BUSYWAIT   (busywait),
        .DATA_MEM_ERROR      (error)
    );

    always #5 clk = ~clk;

    // Reference: byte-array memory, size-aligned base, little-endian gather, extension
    task automatic model_exec(input logic [3:0] rd, input logic [2:0] wr,
                              input logic [31:0] addr, input logic [31:0] wd,
                              output logic exp_err);
        int size;
        logic [31:0] base;
        logic [31:0] v;
        logic inr;
        if (wr[2]) size = (wr[1:0] == 2'b00) ? 1 : (wr[1:0] == 2'b01) ? 2 : 4;
        else       size = (rd[1:0] == 2'b00) ? 1 : (rd[1:0] == 2'b01) ? 2 : 4;
        base    = addr - (addr % 32'(size));
        inr     = (addr / 4) < 32'(DEPTH);
        exp_err = ((addr % 32'(size)) != 0) || !inr || (wr[2] && rd[3]);
        if (wr[2]) begin
            if (inr) for (int i = 0; i < size; i++) mb[base + 32'(i)] = wd[8*i +: 8];
        end else begin
            v = 0;
            if (inr) begin
                for (int i = 0; i < size; i++) v = v | ({24'd0, mb[base + 32'(i)]} << (8*i));
                if (!rd[2] && size == 1) v = 32'($signed(v[7:0]));
                if (!rd[2] && size == 2) v = 32'($signed(v[15:0]));
            end
            exp_rd = v;
        end
    endtask

    // Drive one request from IDLE, hold it while stalled, sample in DONE, return in IDLE
    task automatic do_access(input logic [3:0] rd, input logic [2:0] wr,
                             input logic [31:0] addr, input logic [31:0] wd,
                             output logic [31:0] o_rd, output logic o_err, output int n_busy);
        @(negedge clk);
        mem_read = rd; mem_write = wr; mem_addr = addr; mem_wdata = wd;
        #1;
        n_busy = 0;
        while (busywait === 1'b1 && n_busy < 20) begin
            n_busy++;
            @(posedge clk);
            #1;
        end
        o_rd = read_data;
        o_err = error;
        mem_read = 4'b0; mem_write = 3'b0;
        if (n_busy >= 20) begin
            checks++; failures++;
            $display("FAIL timeout: busywait stuck high addr=%h", addr);
        end
        @(posedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mem_read = MEM_LW; mem_write = 3'b0; mem_addr = 32'h40; mem_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        checks++; if (busywait !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busywait); end
        checks++; if (read_data !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", read_data); end
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", error); end
        mem_read = 4'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk);
        exp_rd = 32'h0;
    endtask

    task automatic test_fill();
        logic [31:0] r; logic e, ee; int nb; logic [31:0] d;
        for (int w = 0; w < int'(DEPTH); w++) begin
            d = $urandom;
            model_exec(4'b0, MEM_SW, 32'(w*4), d, ee);
            do_access(4'b0, MEM_SW, 32'(w*4), d, r, e, nb);
            checks++; if (e !== ee) begin failures++; $display("FAIL fill_err w=%0d got=%b exp=%b", w, e, ee); end
            checks++; if (nb != int'(LAT)) begin failures++; $display("FAIL fill_busy w=%0d got=%0d exp=%0d", w, nb, LAT); end
        end
    endtask

    task automatic test_basic();
        logic [31:0] r; logic e, ee; int nb;
        model_exec(4'b0, MEM_SW, 32'h40, 32'hDEADBEEF, ee);
        do_access(4'b0, MEM_SW, 32'h40, 32'hDEADBEEF, r, e, nb);
        checks++; if (nb != 3) begin failures++; $display("FAIL sw_busy got=%0d exp=3", nb); end
        checks++; if (e !== 1'b0) begin failures++; $display("FAIL sw_err got=%b exp=0", e); end
        model_exec(MEM_LW, 3'b0, 32'h40, 32'h0, ee);
        do_access(MEM_LW, 3'b0, 32'h40, 32'h0, r, e, nb);
        checks++; if (nb != 3) begin failures++; $display("FAIL lw_busy got=%0d exp=3", nb); end
        checks++; if (r !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_data got=%h exp=deadbeef", r); end
        checks++; if (e !== 1'b0) begin failures++; $display("FAIL lw_err got=%b exp=0", e); end
    endtask

    task automatic test_lanes();
        logic [31:0] r; logic e, ee; int nb;
        model_exec(4'b0, MEM_SB, 32'h41, 32'h12, ee);
        do_access(4'b0, MEM_SB, 32'h41, 32'h12, r, e, nb);
        do_access(MEM_LW, 3'b0, 32'h40, 32'h0, r, e, nb);
        checks++; if (r !== 32'hDEAD12EF) begin failures++; $display("FAIL sb_merge got=%h exp=dead12ef", r); end
        do_access(MEM_LB, 3'b0, 32'h43, 32'h0, r, e, nb);
        checks++; if (r !== 32'hFFFFFFDE) begin failures++; $display("FAIL lb got=%h exp=ffffffde", r); end
        do_access(MEM_LBU, 3'b0, 32'h43, 32'h0, r, e, nb);
        checks++; if (r !== 32'h000000DE) begin failures++; $display("FAIL lbu got=%h exp=000000de", r); end
        do_access(MEM_LHU, 3'b0, 32'h42, 32'h0, r, e, nb);
        checks++; if (r !== 32'h0000DEAD) begin failures++; $display("FAIL lhu got=%h exp=0000dead", r); end
        model_exec(MEM_LHU, 3'b0, 32'h42, 32'h0, ee);
    endtask

    task automatic test_misaligned();
        logic [31:0] r, r_ref; logic e, ee; int nb;
        do_access(MEM_LH, 3'b0, 32'h40, 32'h0, r_ref, e, nb);
        model_exec(MEM_LH, 3'b0, 32'h41, 32'h0, ee);
        do_access(MEM_LH, 3'b0, 32'h41, 32'h0, r, e, nb);
        checks++; if (e !== 1'b1) begin failures++; $display("FAIL lh_mis_err got=%b exp=1", e); end
        checks++; if (r !== exp_rd || r !== r_ref) begin failures++; $display("FAIL lh_mis_data got=%h exp=%h", r, exp_rd); end
        model_exec(4'b0, MEM_SW, 32'h102, 32'h1, ee);
        do_access(4'b0, MEM_SW, 32'h102, 32'h1, r, e, nb);
        checks++; if (e !== 1'b1) begin failures++; $display("FAIL sw_mis_err got=%b exp=1", e); end
        model_exec(MEM_LW, 3'b0, 32'h100, 32'h0, ee);
        do_access(MEM_LW, 3'b0, 32'h100, 32'h0, r, e, nb);
        checks++; if (r !== 32'h1) begin failures++; $display("FAIL sw_mis_data got=%h exp=00000001", r); end
        checks++; if (e !== 1'b0) begin failures++; $display("FAIL lw_aligned_err got=%b exp=0", e); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] r; logic e, ee; int nb;
        model_exec(4'b0, MEM_SW, 32'h400, 32'h55, ee);
        do_access(4'b0, MEM_SW, 32'h400, 32'h55, r, e, nb);
        checks++; if (e !== 1'b1) begin failures++; $display("FAIL oor_sw_err got=%b exp=1", e); end
        model_exec(MEM_LW, 3'b0, 32'h400, 32'h0, ee);
        do_access(MEM_LW, 3'b0, 32'h400, 32'h0, r, e, nb);
        checks++; if (e !== 1'b1) begin failures++; $display("FAIL oor_lw_err got=%b exp=1", e); end
        checks++; if (r !== 32'h0) begin failures++; $display("FAIL oor_lw_data got=%h exp=0", r); end
    endtask

    task automatic test_conflict();
        logic [31:0] r; logic e, ee; int nb;
        model_exec(MEM_LW, 3'b0, 32'h40, 32'h0, ee);
        do_access(MEM_LW, 3'b0, 32'h40, 32'h0, r, e, nb);
        model_exec(MEM_LW, MEM_SW, 32'h20, 32'h77, ee);
        do_access(MEM_LW, MEM_SW, 32'h20, 32'h77, r, e, nb);
        checks++; if (e !== 1'b1) begin failures++; $display("FAIL conflict_err got=%b exp=1", e); end
        checks++; if (r !== exp_rd) begin failures++; $display("FAIL conflict_rdata_held got=%h exp=%h", r, exp_rd); end
        do_access(MEM_LW, 3'b0, 32'h20, 32'h0, r, e, nb);
        model_exec(MEM_LW, 3'b0, 32'h20, 32'h0, ee);
        checks++; if (r !== 32'h77) begin failures++; $display("FAIL conflict_wdata got=%h exp=00000077", r); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] r; logic e, ee; int nb;
        @(negedge clk);
        mem_read = 4'b0; mem_write = MEM_SW; mem_addr = 32'h10; mem_wdata = 32'hAA;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (busywait !== 1'b0) begin failures++; $display("FAIL abort_busy_in_reset got=%b exp=0", busywait); end
        @(posedge clk); #1;
        mem_write = 3'b0;
        checks++; if (read_data !== 32'h0) begin failures++; $display("FAIL abort_rdata got=%h exp=0", read_data); end
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL abort_err got=%b exp=0", error); end
        @(negedge clk); rst_n = 1'b1; #1;
        checks++; if (busywait !== 1'b0) begin failures++; $display("FAIL abort_idle_busy got=%b exp=0", busywait); end
        @(posedge clk);
        exp_rd = 32'h0;
        model_exec(MEM_LW, 3'b0, 32'h10, 32'h0, ee);
        do_access(MEM_LW, 3'b0, 32'h10, 32'h0, r, e, nb);
        checks++; if (r !== exp_rd) begin failures++; $display("FAIL abort_preserved got=%h exp=%h", r, exp_rd); end
    endtask

    task automatic test_back_to_back();
        logic ee; logic exp_b;
        model_exec(MEM_LW, 3'b0, 32'h100, 32'h0, ee);
        @(negedge clk);
        mem_read = MEM_LW; mem_write = 3'b0; mem_addr = 32'h100;
        for (int k = 0; k < 2*(int'(LAT)+1); k++) begin
            #1;
            exp_b = (k % (int'(LAT)+1)) < int'(LAT);
            checks++; if (busywait !== exp_b) begin failures++; $display("FAIL b2b_busy cyc=%0d got=%b exp=%b", k, busywait, exp_b); end
            if (!exp_b) begin
                checks++; if (read_data !== exp_rd) begin failures++; $display("FAIL b2b_data cyc=%0d got=%h exp=%h", k, read_data, exp_rd); end
            end
            @(negedge clk);
        end
        mem_read = 4'b0;
        @(posedge clk);
    endtask

    task automatic test_random();
        logic [31:0] r, a, d; logic e, ee; int nb; logic [3:0] rd; logic [2:0] wr;
        logic [3:0] rops [5];
        logic [2:0] wops [3];
        rops = '{MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
        wops = '{MEM_SB, MEM_SH, MEM_SW};
        for (int n = 0; n < 250; n++) begin
            int sel;
            sel = int'($urandom_range(0, 8));
            rd = 4'b0; wr = 3'b0;
            if (sel < 5) rd = rops[sel];
            else if (sel < 8) wr = wops[sel-5];
            else begin rd = rops[$urandom_range(0, 4)]; wr = wops[$urandom_range(0, 2)]; end
            a = 32'($urandom_range(0, 32'h47F));
            d = $urandom;
            model_exec(rd, wr, a, d, ee);
            do_access(rd, wr, a, d, r, e, nb);
            checks++; if (r !== exp_rd) begin failures++; $display("FAIL rnd_rdata n=%0d rd=%b wr=%b a=%h got=%h exp=%h", n, rd, wr, a, r, exp_rd); end
            checks++; if (e !== ee) begin failures++; $display("FAIL rnd_err n=%0d a=%h got=%b exp=%b", n, a, e, ee); end
            checks++; if (nb != int'(LAT)) begin failures++; $display("FAIL rnd_busy n=%0d got=%0d exp=%0d", n, nb, LAT); end
        end
    endtask

    task automatic test_scan();
        logic [31:0] r; logic e, ee; int nb;
        for (int w = 0; w < int'(DEPTH); w++) begin
            model_exec(MEM_LW, 3'b0, 32'(w*4), 32'h0, ee);
            do_access(MEM_LW, 3'b0, 32'(w*4), 32'h0, r, e, nb);
            checks++; if (r !== exp_rd) begin failures++; $display("FAIL scan w=%0d got=%h exp=%h", w, r, exp_rd); end
        end
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b0;
        mem_read = 4'b0; mem_write = 3'b0; mem_addr = 32'h0; mem_wdata = 32'h0;
        checks = 0; failures = 0; exp_rd = 32'h0;
        test_reset();
        test_fill();
        test_basic();
        test_lanes();
        test_misaligned();
        test_out_of_range();
        test_conflict();
        test_reset_abort();
        test_back_to_back();
        test_random();
        test_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
